serial_mag_comp: RTL and testbench

Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned operands. It is built around one instance of the existing 1-bit mux comparator cell (comp_w_mux), which sees one bit pair per clock. Operands are captured on a start handshake and compared one bit per cycle, stopping early at the first differing bit. Registered greater/lesser/equal flags and a done pulse go to downstream control logic.

---
 rtl/serial_mag_comp_pkg.sv | 19 +
 rtl/comp_w_mux.sv | 20 ++
 rtl/serial_mag_comp.sv | 113 +++++++++++
 tb/tb_serial_mag_comp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_comp_pkg.sv
// serial_mag_comp_pkg
//   Shared definitions for the bit-serial magnitude comparator:
//   state encoding and the counter-width helper.
package serial_mag_comp_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  typedef enum logic {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN
  } state_t;

  // Bit-position counter width: max(1, clog2(width)).
  function automatic int CNT_W(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/comp_w_mux.sv
// comp_w_mux
//   1-bit magnitude comparator cell built from 2:1 muxes selected by a_bit.
//   Ports:
//     a_bit, b_bit : bit pair to compare
//     equal        : a_bit == b_bit
//     greater      : a_bit >  b_bit
//     lesser       : a_bit <  b_bit
module comp_w_mux (
  input  logic a_bit,
  input  logic b_bit,
  output logic equal,
  output logic greater,
  output logic lesser
);

  assign equal   = a_bit ? b_bit  : ~b_bit;
  assign greater = a_bit ? ~b_bit : 1'b0;
  assign lesser  = a_bit ? 1'b0   : b_bit;

endmodule

// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Bit-serial, MSB-first unsigned magnitude comparator. Operands are captured
//   on start (in IDLE) and one bit pair per cycle is fed to a comp_w_mux cell;
//   the compare stops at the first differing bit, or after WIDTH equal bits.
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     start, a, b           : compare request and operands (sampled in IDLE)
//     busy                  : compare in progress
//     done                  : one-cycle pulse when result flags update
//     greater/lesser/equal  : registered result, held until the next done
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             lesser,
  output logic             equal
);

  localparam int             CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_gt, r_lt, r_eq;

  logic w_eq, w_gt, w_lt;
  logic w_load, w_shift, w_fin;

  // Current MSB of the shifting operands is the bit under test.
  comp_w_mux u_cell (
    .a_bit   (r_a[WIDTH-1]),
    .b_bit   (r_b[WIDTH-1]),
    .equal   (w_eq),
    .greater (w_gt),
    .lesser  (w_lt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Stop at the first difference or once the LSB has been compared.
        if (!w_eq || (r_cnt == LAST)) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_eq   <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_a   <= a;
        r_b   <= b;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_a   <= r_a << 1;
        r_b   <= r_b << 1;
        r_cnt <= r_cnt + CW'(1);
      end
      // Cell outputs are one-hot, so they land directly as the result.
      if (w_fin) begin
        r_gt <= w_gt;
        r_lt <= w_lt;
        r_eq <= w_eq;
      end
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = r_done;
  assign greater = r_gt;
  assign lesser  = r_lt;
  assign equal   = r_eq;

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp
//   Randomized + directed bench for serial_mag_comp (WIDTH=8 and WIDTH=1),
//   checked every cycle against a cycle-count reference model.
module tb_serial_mag_comp;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, greater, lesser, equal;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, g1, l1, e1;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .greater(greater), .lesser(lesser), .equal(equal)
  );

  serial_mag_comp #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .greater(g1), .lesser(l1), .equal(e1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles from acceptance to done: MSB-relative index of first difference + 1.
  function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--) if (d[i]) return W - i;
    return W;
  endfunction

  // Reference model: busy for lat_of() cycles, then done + flags.
  bit         m_busy, m_done;
  int         m_left;
  logic [2:0] m_flags, m_pend;   // {greater, lesser, equal}

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_left  <= 0;
      m_flags <= '0;
      m_pend  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_flags <= m_pend;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= lat_of(a, b);
        m_pend <= {a > b, a < b, a == b};
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",    32'(busy),    32'(m_busy));
    chk("done",    32'(done),    32'(m_done));
    chk("greater", 32'(greater), 32'(m_flags[2]));
    chk("lesser",  32'(lesser),  32'(m_flags[1]));
    chk("equal",   32'(equal),   32'(m_flags[0]));
  end

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic do_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_lat, input logic [2:0] exp_fl, input string nm);
    int nb;
    bit seen;
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    nb = 0; seen = 1'b0;
    for (int i = 0; i < W + 4 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_done"},  32'(seen), 32'd1);
    chk({nm, "_lat"},   32'(nb),   32'(exp_lat));
    chk({nm, "_flags"}, 32'({greater, lesser, equal}), 32'(exp_fl));
  endtask

  initial begin
    int  nb, ndone;
    bit  seen;
    logic [2:0] fl1;

    chk("model_lat_a5_25", 32'(lat_of(8'hA5, 8'h25)), 32'd1);
    chk("model_lat_3c_3d", 32'(lat_of(8'h3C, 8'h3D)), 32'd8);
    chk("model_lat_10_1f", 32'(lat_of(8'h10, 8'h1F)), 32'd5);
    chk("model_lat_eq",    32'(lat_of(8'h5A, 8'h5A)), 32'd8);

    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({busy, done, greater, lesser, equal}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmp(8'hA5, 8'h25, 1, 3'b100, "a5_25");
    @(negedge clk);
    do_cmp(8'h3C, 8'h3D, 8, 3'b010, "3c_3d");
    do_cmp(8'h5A, 8'h5A, 8, 3'b001, "eq");
    repeat (4) @(negedge clk);
    chk("eq_hold", 32'({greater, lesser, equal}), 32'b001);

    // Second start while busy must be ignored.
    start = 1'b1; a = 8'h10; b = 8'h1F;
    @(negedge clk);
    start = 1'b0; nb = 0; seen = 1'b0;
    for (int i = 0; i < W + 4 && !seen; i++) begin
      if (i == 1) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      else start = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done",  32'(seen), 32'd1);
    chk("ign_lat",   32'(nb),   32'd5);
    chk("ign_flags", 32'({greater, lesser, equal}), 32'b010);
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    chk("ign_no_2nd_done", 32'(ndone), 32'd0);

    // Reset in the middle of a compare.
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outs", 32'({busy, done, greater, lesser, equal}), 32'd0);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_cmp(8'h80, 8'h7F, 1, 3'b100, "after_rst");

    // Back-to-back: start accepted in the done cycle.
    @(negedge clk);
    do_cmp(8'h20, 8'h10, 3, 3'b100, "b2b_first");
    start = 1'b1; a = 8'h00; b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("b2b_done",  32'(done), 32'd1);
    chk("b2b_flags", 32'({greater, lesser, equal}), 32'b010);

    // WIDTH=1 instance: always one cycle.
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("w1_done",  32'(done1), 32'd1);
    chk("w1_flags", 32'({g1, l1, e1}), 32'b100);
    repeat (12) begin
      start1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom);
      fl1 = {a1 > b1, a1 < b1, a1 == b1};
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      chk("w1_rand_done",  32'(done1), 32'd1);
      chk("w1_rand_flags", 32'({g1, l1, e1}), 32'(fl1));
    end

    // Random traffic: starts at any time, operand churn, biased near-equal pairs.
    repeat (3000) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
        default: b = W'($urandom);
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
